// File: rtl/rx_sd_pkg.sv
// Shared RX SD chain definitions: default sizes, complex sample packing and the bank selector type.
package rx_sd_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int DEPTH_DEF      = 13;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_t;

    // Complex samples are packed as {I, Q} with I in the upper half.
    function automatic logic [2*DATA_WIDTH_DEF-1:0] cplx_pack(
        input logic signed [DATA_WIDTH_DEF-1:0] re,
        input logic signed [DATA_WIDTH_DEF-1:0] im
    );
        return {re, im};
    endfunction

    function automatic logic signed [DATA_WIDTH_DEF-1:0] cplx_re(
        input logic [2*DATA_WIDTH_DEF-1:0] s
    );
        return s[2*DATA_WIDTH_DEF-1:DATA_WIDTH_DEF];
    endfunction

    function automatic logic signed [DATA_WIDTH_DEF-1:0] cplx_im(
        input logic [2*DATA_WIDTH_DEF-1:0] s
    );
        return s[DATA_WIDTH_DEF-1:0];
    endfunction

    function automatic bank_t bank_flip(input bank_t b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage

// File: rtl/ser_par_bank.sv
// One storage bank of the ping-pong collector: indexed sample write, parallel read, synchronous clear.
module ser_par_bank #(
    parameter  int CPLX_WIDTH = 32,
    parameter  int DEPTH      = 13,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             clear,
    input  logic                             we,
    input  logic [IDX_W-1:0]                 idx,
    input  logic [CPLX_WIDTH-1:0]            data,
    output logic [DEPTH-1:0][CPLX_WIDTH-1:0] samples
);

    always_ff @(posedge clk) begin
        if (clear) begin
            samples <= '0;
        end else if (we) begin
            samples[idx] <= data;
        end
    end

endmodule

// File: rtl/ser_par_ch_pp.sv
// Ping-pong serial-to-parallel collector: fills one bank with DEPTH complex samples while the
// equalizer holds the other, with valid/ready flow control, SOF resync and short-frame error pulses.
module ser_par_ch_pp
    import rx_sd_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int DEPTH      = DEPTH_DEF,
    localparam int CPLX_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             i_rst,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic                             i_sof,
    input  logic [CPLX_WIDTH-1:0]            i_data,
    output logic [DEPTH-1:0][CPLX_WIDTH-1:0] o_data,
    output logic                             o_valid,
    input  logic                             i_ack,
    output logic                             o_done_equ,
    output logic                             o_err_short
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0]                 wr_idx;
    logic [IDX_W-1:0]                 wr_addr;
    bank_t                            wr_bank;
    bank_t                            rd_bank;
    logic [1:0]                       full;
    logic [1:0]                       full_next;
    logic                             accept;
    logic                             complete;
    logic                             release_rd;
    logic [DEPTH-1:0][CPLX_WIDTH-1:0] bank0_samples;
    logic [DEPTH-1:0][CPLX_WIDTH-1:0] bank1_samples;
    logic [DEPTH-1:0][CPLX_WIDTH-1:0] held;

    assign o_ready    = !full[wr_bank] && !i_rst;
    assign accept     = i_valid && o_ready;
    assign complete   = accept && !i_sof && (wr_idx == LAST_IDX);
    assign release_rd = i_ack && full[rd_bank];
    assign wr_addr    = i_sof ? '0 : wr_idx;
    assign o_valid    = full[rd_bank];

    // Completion and release always hit different banks, so both updates apply.
    always_comb begin
        full_next = full;
        if (complete) full_next[wr_bank] = 1'b1;
        if (release_rd) full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_idx      <= '0;
            wr_bank     <= BANK0;
            rd_bank     <= BANK0;
            full        <= '0;
            o_done_equ  <= 1'b0;
            o_err_short <= 1'b0;
        end else begin
            full        <= full_next;
            o_done_equ  <= complete;
            o_err_short <= accept && i_sof && (wr_idx != '0);
            if (accept) begin
                if (i_sof) begin
                    wr_idx <= IDX_W'(1);
                end else if (complete) begin
                    wr_idx  <= '0;
                    wr_bank <= bank_flip(wr_bank);
                end else begin
                    wr_idx <= wr_idx + IDX_W'(1);
                end
            end
            if (release_rd) rd_bank <= bank_flip(rd_bank);
        end
    end

    ser_par_bank #(.CPLX_WIDTH(CPLX_WIDTH), .DEPTH(DEPTH)) u_bank0 (
        .clk     (clk),
        .clear   (i_rst),
        .we      (accept && (wr_bank == BANK0)),
        .idx     (wr_addr),
        .data    (i_data),
        .samples (bank0_samples)
    );

    ser_par_bank #(.CPLX_WIDTH(CPLX_WIDTH), .DEPTH(DEPTH)) u_bank1 (
        .clk     (clk),
        .clear   (i_rst),
        .we      (accept && (wr_bank == BANK1)),
        .idx     (wr_addr),
        .data    (i_data),
        .samples (bank1_samples)
    );

    // Without a full read bank the output freezes on whatever was last presented.
    always_comb begin
        o_data = held;
        if (o_valid) o_data = (rd_bank == BANK0) ? bank0_samples : bank1_samples;
    end

    always_ff @(posedge clk) begin
        if (i_rst) held <= '0;
        else       held <= o_data;
    end

endmodule

// File: tb/tb_ser_par_ch_pp.sv
// Bench for ser_par_ch_pp: directed scenarios plus random traffic against a frame-queue model.
module tb_ser_par_ch_pp;
    import rx_sd_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 13;
    localparam int CW    = 2 * DW;

    typedef logic [DEPTH-1:0][CW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          i_rst, i_valid, i_sof, i_ack;
    logic [CW-1:0] i_data;
    logic          o_ready, o_valid, o_done_equ, o_err_short;
    frame_t        o_data;

    ser_par_ch_pp #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sof       (i_sof),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ack       (i_ack),
        .o_done_equ  (o_done_equ),
        .o_err_short (o_err_short)
    );

    always #5 clk = ~clk;

    // Model: completed frames waiting for the equalizer, oldest first, plus the frame being assembled.
    frame_t        frames[$];
    logic [CW-1:0] partial[$];
    bit            exp_done, exp_err, mdl_ready, acc, got_ready;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic cycle(input bit v, input bit sof, input logic [CW-1:0] d, input bit ack);
        frame_t f;
        i_valid = v; i_sof = sof; i_data = d; i_ack = ack;
        #1;
        got_ready = o_ready;
        mdl_ready = (frames.size() < 2);
        acc = v && mdl_ready;
        @(posedge clk);
        exp_done = 0; exp_err = 0;
        if (ack && frames.size() > 0) void'(frames.pop_front());
        if (acc) begin
            if (sof) begin
                exp_err = (partial.size() != 0);
                partial.delete();
                partial.push_back(d);
            end else begin
                partial.push_back(d);
                if (partial.size() == DEPTH) begin
                    for (int k = 0; k < DEPTH; k++) f[k] = partial[k];
                    frames.push_back(f);
                    partial.delete();
                    exp_done = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        i_rst = 1; i_valid = 0; i_sof = 0; i_ack = 0; i_data = '0;
        repeat (n) @(negedge clk);
        frames.delete(); partial.delete();
        exp_done = 0; exp_err = 0;
    endtask

    task automatic test_reset();
        i_rst = 1; i_valid = 1; i_sof = 1; i_data = CW'(7); i_ack = 1;
        repeat (2) @(negedge clk);
        n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0b want 0", o_ready); end
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", o_valid); end
        n_vec++; if (o_data !== '0) begin n_err++; $display("FAIL reset_data got %h want 0", o_data); end
        n_vec++; if ({o_done_equ, o_err_short} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got %b want 00", {o_done_equ, o_err_short}); end
        i_rst = 0; i_valid = 0; i_sof = 0; i_ack = 0;
        frames.delete(); partial.delete();
        #1;
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got %0b want 1", o_ready); end
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int dones = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            cycle(1, k == 1, CW'(k), 0);
            if (o_done_equ) dones++;
            n_vec++; if (got_ready !== 1'b1) begin n_err++; $display("FAIL single_ready k=%0d got %0b want 1", k, got_ready); end
            n_vec++; if (o_done_equ !== exp_done) begin n_err++; $display("FAIL single_done k=%0d got %0b want %0b", k, o_done_equ, exp_done); end
            n_vec++; if (o_valid !== (frames.size() > 0)) begin n_err++; $display("FAIL single_valid k=%0d got %0b want %0b", k, o_valid, frames.size() > 0); end
        end
        n_vec++; if (o_data[0] !== CW'(1)) begin n_err++; $display("FAIL single_data0 got %h want 1", o_data[0]); end
        n_vec++; if (o_data[DEPTH-1] !== CW'(13)) begin n_err++; $display("FAIL single_data12 got %h want d", o_data[DEPTH-1]); end
        n_vec++; if (dones !== 1) begin n_err++; $display("FAIL single_done_count got %0d want 1", dones); end
        #1;
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_end got %0b want 1", o_ready); end
        cycle(0, 0, '0, 1);
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL single_after_ack_valid got %0b want 0", o_valid); end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] data[3*DEPTH];
        frame_t        f2;
        int            idx = 0;
        for (int k = 0; k < 3 * DEPTH; k++) data[k] = CW'($urandom);
        for (int k = 0; k < DEPTH; k++) f2[k] = data[DEPTH + k];
        for (int c = 0; c < 3 * DEPTH + 4; c++) begin
            cycle(1, (idx % DEPTH) == 0, data[idx], 0);
            if (acc) idx++;
            n_vec++; if (got_ready !== mdl_ready) begin n_err++; $display("FAIL b2b_ready c=%0d got %0b want %0b", c, got_ready, mdl_ready); end
            n_vec++; if (o_done_equ !== exp_done) begin n_err++; $display("FAIL b2b_done c=%0d got %0b want %0b", c, o_done_equ, exp_done); end
            if (frames.size() > 0) begin
                n_vec++; if (o_data !== frames[0]) begin n_err++; $display("FAIL b2b_data c=%0d got %h want %h", c, o_data, frames[0]); end
            end
        end
        #1;
        n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready got %0b want 0", o_ready); end
        n_vec++; if (idx !== 2 * DEPTH) begin n_err++; $display("FAIL b2b_stall_count got %0d want %0d", idx, 2 * DEPTH); end
        cycle(1, 1, data[idx], 1);
        n_vec++; if (got_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ack_ready got %0b want 0", got_ready); end
        n_vec++; if (o_data !== f2) begin n_err++; $display("FAIL b2b_frame2 got %h want %h", o_data, f2); end
        for (int c = 0; c < DEPTH + 4 && idx < 3 * DEPTH; c++) begin
            cycle(1, (idx % DEPTH) == 0, data[idx], 0);
            if (acc) idx++;
            n_vec++; if (got_ready !== mdl_ready) begin n_err++; $display("FAIL b2b3_ready c=%0d got %0b want %0b", c, got_ready, mdl_ready); end
            n_vec++; if (o_done_equ !== exp_done) begin n_err++; $display("FAIL b2b3_done c=%0d got %0b want %0b", c, o_done_equ, exp_done); end
        end
        n_vec++; if (idx !== 3 * DEPTH) begin n_err++; $display("FAIL b2b_frame3_count got %0d want %0d", idx, 3 * DEPTH); end
        repeat (2) begin
            cycle(0, 0, '0, 1);
            n_vec++; if (o_valid !== (frames.size() > 0)) begin n_err++; $display("FAIL b2b_drain_valid got %0b want %0b", o_valid, frames.size() > 0); end
            if (frames.size() > 0) begin
                n_vec++; if (o_data !== frames[0]) begin n_err++; $display("FAIL b2b_drain_data got %h want %h", o_data, frames[0]); end
            end
        end
    endtask

    task automatic test_resync();
        int errs = 0;
        for (int k = 0; k < 5 + 1 + DEPTH - 1; k++) begin
            if (k == 5) cycle(1, 1, CW'(100), 0);
            else        cycle(1, k == 0, cplx_pack(DW'(-k), DW'(k + 1)), 0);
            if (o_err_short) errs++;
            n_vec++; if (o_err_short !== exp_err) begin n_err++; $display("FAIL resync_err k=%0d got %0b want %0b", k, o_err_short, exp_err); end
            n_vec++; if (o_done_equ !== exp_done) begin n_err++; $display("FAIL resync_done k=%0d got %0b want %0b", k, o_done_equ, exp_done); end
        end
        n_vec++; if (errs !== 1) begin n_err++; $display("FAIL resync_err_count got %0d want 1", errs); end
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL resync_valid got %0b want 1", o_valid); end
        n_vec++; if (o_data[0] !== CW'(100)) begin n_err++; $display("FAIL resync_data0 got %h want 64", o_data[0]); end
        n_vec++; if (o_data[1] !== cplx_pack(DW'(-6), DW'(7))) begin n_err++; $display("FAIL resync_data1 got %h want %h", o_data[1], cplx_pack(DW'(-6), DW'(7))); end
        cycle(0, 0, '0, 1);
    endtask

    task automatic test_ack_collide();
        frame_t fb;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < DEPTH; k++) begin
                logic [CW-1:0] d;
                d = CW'($urandom);
                if (f == 1) fb[k] = d;
                cycle(1, k == 0, d, (f == 1) && (k == DEPTH - 1));
                n_vec++; if (got_ready !== mdl_ready) begin n_err++; $display("FAIL collide_ready f=%0d k=%0d got %0b want %0b", f, k, got_ready, mdl_ready); end
                n_vec++; if (o_valid !== (frames.size() > 0)) begin n_err++; $display("FAIL collide_valid f=%0d k=%0d got %0b want %0b", f, k, o_valid, frames.size() > 0); end
            end
        end
        n_vec++; if (o_data !== fb) begin n_err++; $display("FAIL collide_data got %h want %h", o_data, fb); end
        n_vec++; if (o_done_equ !== 1'b1) begin n_err++; $display("FAIL collide_done got %0b want 1", o_done_equ); end
        cycle(0, 0, '0, 1);
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL collide_drain_valid got %0b want 0", o_valid); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < DEPTH + 4; k++) cycle(1, k == 0, CW'($urandom), 0);
        n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_valid got %0b want 1", o_valid); end
        i_rst = 1; i_valid = 1; i_sof = 0; i_data = CW'(5); i_ack = 0;
        @(negedge clk);
        n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %0b want 0", o_valid); end
        n_vec++; if (o_data !== '0) begin n_err++; $display("FAIL rstmid_data got %h want 0", o_data); end
        n_vec++; if ({o_done_equ, o_err_short} !== 2'b00) begin n_err++; $display("FAIL rstmid_pulses got %b want 00", {o_done_equ, o_err_short}); end
        n_vec++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready got %0b want 0", o_ready); end
        i_rst = 0; i_valid = 0;
        frames.delete(); partial.delete();
        #1;
        n_vec++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_release_ready got %0b want 1", o_ready); end
        @(negedge clk);
    endtask

    task automatic test_idle();
        for (int k = 0; k < DEPTH + 7; k++) begin
            if (k >= 3 && k < 7) cycle(0, 0, CW'($urandom), 1);
            else                 cycle(1, k == 0, CW'($urandom), 0);
            n_vec++; if (got_ready !== mdl_ready) begin n_err++; $display("FAIL idle_ready k=%0d got %0b want %0b", k, got_ready, mdl_ready); end
            n_vec++; if (o_valid !== (frames.size() > 0)) begin n_err++; $display("FAIL idle_valid k=%0d got %0b want %0b", k, o_valid, frames.size() > 0); end
            n_vec++; if (o_done_equ !== exp_done) begin n_err++; $display("FAIL idle_done k=%0d got %0b want %0b", k, o_done_equ, exp_done); end
        end
        n_vec++; if (frames.size() != 1 || o_data !== frames[0]) begin n_err++; $display("FAIL idle_frame got %h want one stored frame", o_data); end
        cycle(0, 0, '0, 1);
    endtask

    task automatic test_random();
        logic [CW-1:0] d;
        bit            v, s, pend;
        pend = 0; d = '0; s = 0;
        for (int c = 0; c < 600; c++) begin
            if (!pend) begin
                v = ($urandom_range(3) != 0);
                s = ($urandom_range(19) == 0);
                d = CW'($urandom);
            end
            cycle(v, s, d, $urandom_range(2) == 0);
            pend = v && !acc;
            n_vec++; if (got_ready !== mdl_ready) begin n_err++; $display("FAIL rand_ready c=%0d got %0b want %0b", c, got_ready, mdl_ready); end
            n_vec++; if (o_valid !== (frames.size() > 0)) begin n_err++; $display("FAIL rand_valid c=%0d got %0b want %0b", c, o_valid, frames.size() > 0); end
            n_vec++; if (o_done_equ !== exp_done) begin n_err++; $display("FAIL rand_done c=%0d got %0b want %0b", c, o_done_equ, exp_done); end
            n_vec++; if (o_err_short !== exp_err) begin n_err++; $display("FAIL rand_err c=%0d got %0b want %0b", c, o_err_short, exp_err); end
            if (frames.size() > 0) begin
                n_vec++; if (o_data !== frames[0]) begin n_err++; $display("FAIL rand_data c=%0d got %h want %h", c, o_data, frames[0]); end
            end
        end
    endtask

    initial begin
        i_rst = 1; i_valid = 0; i_sof = 0; i_ack = 0; i_data = '0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_resync();
        test_ack_collide();
        test_reset_mid();
        test_idle();
        apply_reset(2);
        i_rst = 0;
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
